// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the shift sequencer: operation mode
//               encodings and the sequencer FSM state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Operation encodings carried on the 3-bit mode port; 5..7 are reserved
  localparam logic [2:0] MODE_LSR = 3'd0;
  localparam logic [2:0] MODE_ASR = 3'd1;
  localparam logic [2:0] MODE_LSL = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Purely combinational single-step shifter. Produces the next
//               register value and carry for one step of the selected mode.
// Ports       : i_q       - current register contents
//               i_mode    - operation (LSR/ASR/LSL/ROR/ROL, others reserved)
//               i_ser_in  - fill bit for LSR and LSL
//               i_carry   - current carry, passed through for reserved modes
//               o_q       - register contents after one step
//               o_carry   - bit shifted or rotated out by this step
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [2:0]       i_mode,
  input  logic             i_ser_in,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_q,
  output logic             o_carry
);

  always_comb begin
    // Reserved modes fall through with both values held
    o_q     = i_q;
    o_carry = i_carry;
    case (i_mode)
      MODE_LSR: begin
        o_q     = {i_ser_in, i_q[WIDTH-1:1]};
        o_carry = i_q[0];
      end
      MODE_ASR: begin
        o_q     = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
        o_carry = i_q[0];
      end
      MODE_LSL: begin
        o_q     = {i_q[WIDTH-2:0], i_ser_in};
        o_carry = i_q[WIDTH-1];
      end
      MODE_ROR: begin
        o_q     = {i_q[0], i_q[WIDTH-1:1]};
        o_carry = i_q[0];
      end
      MODE_ROL: begin
        o_q     = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_carry = i_q[WIDTH-1];
      end
      default: begin
      end
    endcase
  end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-step shift/rotate sequencer. In IDLE the register can be
//               parallel loaded, or a start captures a mode and step count;
//               the FSM then performs one single-bit step per clock in SHIFT
//               and pulses done for one cycle in DONE.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous active-high reset
//               load      - parallel load request (IDLE only, beats start)
//               load_val  - parallel load data
//               start     - operation request (IDLE only)
//               amount    - step count, clamped to WIDTH
//               mode      - 0 LSR, 1 ASR, 2 LSL, 3 ROR, 4 ROL, 5-7 reserved
//               ser_in    - fill bit for LSR/LSL, sampled live each step
//               q         - register contents
//               busy      - high while in SHIFT
//               done      - one-cycle completion pulse
//               carry_out - last bit shifted or rotated out
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             carry_out
);

  localparam logic [AMT_W-1:0] c_AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] c_CNT_ONE = AMT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_carry;
  logic             w_carry_nxt;
  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_nxt;
  logic [AMT_W-1:0] w_amt_clamped;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_carry;

  assign w_amt_clamped = (amount > c_AMT_MAX) ? c_AMT_MAX : amount;

  // Step datapath works on the captured mode so port changes mid-operation
  // have no effect; ser_in is deliberately taken live.
  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_q      (r_q),
    .i_mode   (r_mode),
    .i_ser_in (ser_in),
    .i_carry  (r_carry),
    .o_q      (w_step_q),
    .o_carry  (w_step_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_q_nxt = load_val;
        end else if (start) begin
          w_mode_nxt = mode;
          w_cnt_nxt  = w_amt_clamped;
          // A zero-length operation still produces its done pulse
          w_state_nxt = (w_amt_clamped == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_q_nxt     = w_step_q;
        w_carry_nxt = w_step_carry;
        w_cnt_nxt   = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign q         = r_q;
  assign carry_out = r_carry;
  assign busy      = (r_state == ST_SHIFT);
  assign done      = (r_state == ST_DONE);

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer (WIDTH=8 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       load8 = 0, start8 = 0, ser8 = 0;
  logic [7:0] lval8 = 0;
  logic [3:0] amt8 = 0;
  logic [2:0] mode8 = 0;
  logic [7:0] q8;
  logic       busy8, done8, cy8;

  // WIDTH=16 instance
  logic        load16 = 0, start16 = 0, ser16 = 0;
  logic [15:0] lval16 = 0;
  logic [4:0]  amt16 = 0;
  logic [2:0]  mode16 = 0;
  logic [15:0] q16;
  logic        busy16, done16, cy16;

  shift_sequencer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .load(load8), .load_val(lval8), .start(start8),
    .amount(amt8), .mode(mode8), .ser_in(ser8), .q(q8), .busy(busy8),
    .done(done8), .carry_out(cy8)
  );

  shift_sequencer #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .load(load16), .load_val(lval16), .start(start16),
    .amount(amt16), .mode(mode16), .ser_in(ser16), .q(q16), .busy(busy16),
    .done(done16), .carry_out(cy16)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state for the 8-bit instance
  logic [63:0] mq8 = 0;
  logic        mc8 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One step of each operation expressed as integer arithmetic on a W-bit value
  function automatic logic [64:0] model_step(input logic [63:0] v, input int m,
                                             input logic s, input logic c, input int w);
    logic [63:0] mask, msb, nv;
    logic        nc;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    nv = v; nc = c;
    case (m)
      0: begin nv = (v >> 1) | (s ? msb : 64'd0);           nc = v[0]; end
      1: begin nv = (v >> 1) | (v & msb);                    nc = v[0]; end
      2: begin nv = ((v << 1) | {63'd0, s}) & mask;          nc = (v & msb) != 0; end
      3: begin nv = (v >> 1) | (v[0] ? msb : 64'd0);        nc = v[0]; end
      4: begin nv = ((v << 1) & mask) | ((v & msb) != 0);    nc = (v & msb) != 0; end
      default: ;
    endcase
    return {nc, nv};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_load8(input logic [7:0] v);
    load8 = 1; lval8 = v;
    tick();
    load8 = 0;
    mq8 = {56'd0, v};
    chk("load_q", {56'd0, q8}, mq8);
  endtask

  // Runs one operation on the 8-bit instance. ser_mode: 0/1 fixed fill,
  // 2 random fill per step. noise: poke load/start/mode/amount while busy.
  task automatic op8(input int m, input int amt, input int ser_mode, input bit noise);
    int steps;
    logic [64:0] r;
    steps = (amt > 8) ? 8 : amt;
    start8 = 1; mode8 = 3'(m); amt8 = 4'(amt);
    ser8 = (ser_mode == 2) ? 1'($urandom) : 1'(ser_mode);
    tick();
    start8 = 0;
    if (noise) begin
      load8 = 1; lval8 = 8'($urandom); start8 = 1;
      mode8 = 3'($urandom); amt8 = 4'($urandom);
    end
    if (steps == 0) begin
      chk("zero_done", {63'd0, done8}, 64'd1);
      chk("zero_busy", {63'd0, busy8}, 64'd0);
      chk("zero_q", {56'd0, q8}, mq8);
      chk("zero_cy", {63'd0, cy8}, {63'd0, mc8});
    end else begin
      chk("start_busy", {63'd0, busy8}, 64'd1);
      for (int k = 1; k <= steps; k++) begin
        ser8 = (ser_mode == 2) ? 1'($urandom) : 1'(ser_mode);
        r = model_step(mq8, m, ser8, mc8, 8);
        tick();
        mq8 = r[63:0]; mc8 = r[64];
        chk("step_q", {56'd0, q8}, mq8);
        chk("step_cy", {63'd0, cy8}, {63'd0, mc8});
        chk("step_busy", {63'd0, busy8}, (k < steps) ? 64'd1 : 64'd0);
        chk("step_done", {63'd0, done8}, (k < steps) ? 64'd0 : 64'd1);
      end
    end
    tick();
    load8 = 0; start8 = 0;
    chk("post_done", {63'd0, done8}, 64'd0);
    chk("post_busy", {63'd0, busy8}, 64'd0);
    chk("post_q", {56'd0, q8}, mq8);
  endtask

  initial begin
    int bcnt;
    // Reset state
    #2;
    chk("rst_q", {56'd0, q8}, 64'd0);
    chk("rst_busy", {63'd0, busy8}, 64'd0);
    chk("rst_done", {63'd0, done8}, 64'd0);
    chk("rst_cy", {63'd0, cy8}, 64'd0);
    tick(); tick();
    reset = 0;
    tick();

    // ASR 0x96 by 3 -> CB, E5, F2 with carries 0,1,1
    do_load8(8'h96);
    op8(1, 3, 0, 0);
    chk("asr_final", {56'd0, q8}, 64'hF2);
    chk("asr_cy", {63'd0, cy8}, 64'd1);

    // LSL 0xF1 by 2 with zero fill; ROL 0x81 by 1
    do_load8(8'hF1);
    op8(2, 2, 0, 0);
    chk("lsl_final", {56'd0, q8}, 64'hC4);
    chk("lsl_cy", {63'd0, cy8}, 64'd1);
    do_load8(8'h81);
    op8(4, 1, 0, 0);
    chk("rol_final", {56'd0, q8}, 64'h03);
    chk("rol_cy", {63'd0, cy8}, 64'd1);

    // LSR with one-fill, then an over-range amount clamped to 8
    do_load8(8'h00);
    op8(0, 4, 1, 0);
    chk("lsr4_final", {56'd0, q8}, 64'hF0);
    op8(0, 15, 1, 0);
    chk("lsr15_final", {56'd0, q8}, 64'hFF);

    // Zero amount, and load winning over start
    do_load8(8'h5A);
    op8(3, 0, 0, 0);
    load8 = 1; start8 = 1; lval8 = 8'h3C; mode8 = 3'd0; amt8 = 4'd3;
    tick();
    load8 = 0; start8 = 0; mq8 = 64'h3C;
    chk("ld_st_q", {56'd0, q8}, 64'h3C);
    chk("ld_st_busy", {63'd0, busy8}, 64'd0);
    tick();
    chk("ld_st_idle", {62'd0, busy8, done8}, 64'd0);

    // Load/start/mode/amount activity during SHIFT and DONE is ignored
    op8(3, 5, 0, 1);

    // Reset two steps into a 5-step ROR
    do_load8(8'hA7);
    start8 = 1; mode8 = 3'd3; amt8 = 4'd5;
    tick();
    start8 = 0;
    tick(); tick();
    chk("pre_rst_busy", {63'd0, busy8}, 64'd1);
    reset = 1;
    #1;
    chk("mid_rst_q", {56'd0, q8}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy8}, 64'd0);
    tick();
    chk("mid_rst_done", {63'd0, done8}, 64'd0);
    reset = 0; mq8 = 0; mc8 = 0;
    tick();
    chk("after_rst_done", {63'd0, done8}, 64'd0);
    do_load8(8'h6D);
    op8(4, 3, 0, 0);

    // Randomised operations, including reserved modes and clamped amounts
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) do_load8(8'($urandom));
      op8(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 2,
          1'($urandom_range(0, 1)));
    end

    // WIDTH=16: full rotate returns the original value, busy for 16 cycles
    load16 = 1; lval16 = 16'h8001;
    tick();
    load16 = 0;
    chk("w16_load", {48'd0, q16}, 64'h8001);
    start16 = 1; mode16 = 3'd3; amt16 = 5'd16;
    tick();
    start16 = 0;
    bcnt = 0;
    for (int i = 0; i < 40 && !done16; i++) begin
      if (busy16) bcnt++;
      tick();
    end
    chk("w16_busy_cycles", 64'(bcnt), 64'd16);
    chk("w16_done", {63'd0, done16}, 64'd1);
    chk("w16_q", {48'd0, q16}, 64'h8001);
    chk("w16_cy", {63'd0, cy16}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_shift_sequencer
`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: register width in bits, legal range 2..64.
REQ-002 The block SHALL have derived parameter AMT_W, default $clog2(WIDTH)+1: width of the amount port.
REQ-003 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 load  input  1  Synchronous parallel load request.
REQ-006 load_val  input  WIDTH  Parallel load data.
REQ-007 start  input  1  Shift-operation request, sampled when the state is IDLE.
REQ-008 amount  input  AMT_W  Number of single-bit steps to perform.
REQ-009 mode  input  3  Operation: 0 LSR, 1 ASR, 2 LSL, 3 ROR, 4 ROL, 5-7 reserved.
REQ-010 ser_in  input  1  Fill bit for LSR and LSL.
REQ-011 q  output  WIDTH  Register contents.
REQ-012 busy  output  1  High while in SHIFT.
REQ-013 done  output  1  One-cycle pulse on completion.
REQ-014 carry_out  output  1  Last bit shifted or rotated out.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, load=1 SHALL set q to load_val on the next edge.
REQ-017 In IDLE, start=1 with load=0 SHALL capture mode and amount, clamping amount values above WIDTH to WIDTH.
REQ-018 On a start capture with a nonzero amount, the FSM SHALL enter SHIFT with cnt equal to the captured amount.
REQ-019 On a start capture with amount=0, the FSM SHALL go directly to DONE, leaving q and carry_out unchanged.
REQ-020 When load and start are both high in IDLE, the load SHALL win and the start SHALL be dropped.
REQ-021 In SHIFT, each edge SHALL perform exactly one step on q, update carry_out, and decrement cnt.
REQ-022 When cnt is 1 at an edge, that edge SHALL perform the final step and move the FSM to DONE.
REQ-023 Latency: with start sampled at edge 0, steps SHALL occur at edges 1..N and done SHALL be high for exactly the cycle after edge N.
REQ-024 LSR SHALL set q to {ser_in, q[WIDTH-1:1]} with carry_out = old q[0].
REQ-025 ASR SHALL set q to {q[WIDTH-1], q[WIDTH-1:1]} with carry_out = old q[0].
REQ-026 LSL SHALL set q to {q[WIDTH-2:0], ser_in} with carry_out = old q[WIDTH-1].
REQ-027 ROR SHALL set q to {q[0], q[WIDTH-1:1]} with carry_out = old q[0].
REQ-028 ROL SHALL set q to {q[WIDTH-2:0], q[WIDTH-1]} with carry_out = old q[WIDTH-1].
REQ-029 Reserved modes SHALL run the step count with q and carry_out held.
REQ-030 The captured mode SHALL be used for the whole operation; changes on the mode and amount ports during SHIFT SHALL be ignored.
REQ-031 load and start SHALL be ignored in SHIFT and DONE.
REQ-032 ser_in SHALL be sampled live on every step.
REQ-033 DONE SHALL return to IDLE after one cycle unconditionally.
REQ-034 busy SHALL be 0 in IDLE and DONE.
REQ-035 done SHALL be 1 only in DONE.

Reset
REQ-036 While reset is high, the block SHALL hold q=0, carry_out=0, busy=0, done=0, cnt=0 and state=IDLE, asynchronously.
REQ-037 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-038 After reset deasserts, the first edge SHALL behave as IDLE.

Structure
REQ-039 A shared package shift_pkg SHALL hold the mode encodings (MODE_LSR..MODE_ROL) and the state enum (ST_IDLE, ST_SHIFT, ST_DONE).
REQ-040 A single combinational sub-module, shift_step, SHALL compute the next q and carry_out for one step from q, mode and ser_in, and SHALL be instantiated once.
REQ-041 The FSM, counter and registers SHALL reside in shift_sequencer.

Verification
REQ-042 WIDTH=8: load 0x96, ASR, amount 3 -> q steps 0xCB, 0xE5, 0xF2; carry_out 0, 1, 1; done at cycle 4 after start.
REQ-043 WIDTH=8: load 0xF1, LSL, amount 2, ser_in=0 -> q=0xC4, carry_out=1; load 0x81, ROL, amount 1 -> q=0x03, carry_out=1.
REQ-044 WIDTH=8: load 0x00, LSR, ser_in=1, amount 4 -> q=0xF0; amount 15 -> clamped to 8, q=0xFF, done after 8 steps.
REQ-045 Boundaries: amount 0 -> done the cycle after start with q unchanged; load and start together in IDLE -> q=load_val, no busy; start or load during SHIFT -> ignored.
REQ-046 Reset at step 2 of a 5-step ROR -> q=0, busy=0, no done pulse; a new operation after release completes normally.
REQ-047 WIDTH=16: load 0x8001, ROR, amount 16 -> q=0x8001, carry_out=1, busy high for 16 cycles.
